// File: rtl/traffic_spawner.sv
// Pseudo-random car/no-car generator for a Traffic row: LFSR draws shaped by a run/gap FSM.
// Optional saturating carCount output is compiled in when TRAFFIC_SPAWN_COUNT_EN is defined.
module traffic_spawner #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned DIVIDE  = 8,
  parameter int unsigned MAX_RUN = 3,
  parameter int unsigned MIN_GAP = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] density,
  output logic       randomNumber,
  output logic       step
`ifdef TRAFFIC_SPAWN_COUNT_EN
  ,
  output logic [7:0] carCount
`endif
);

  // An all-zero seed would lock the LFSR, so it falls back to the default pattern.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'd0) ? 16'hACE1 : SEED;
  localparam logic [15:0] DIV_LAST  = 16'(DIVIDE - 1);
  localparam logic [3:0]  MAX_RUN_C = 4'(MAX_RUN);
  localparam logic [3:0]  MIN_GAP_C = 4'(MIN_GAP);

  typedef enum logic [1:0] {FREE, CAR, GAP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  run_q, run_d;
  logic [3:0]  gap_q, gap_d;
  logic        rn_d;
  logic [15:0] lfsr;
  logic [15:0] div_cnt;
  logic [3:0]  threshold;
  logic        candidate;
  logic        feedback;
  logic        step_edge;

  assign step_edge = enable && (div_cnt == DIV_LAST);
  assign feedback  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign candidate = (lfsr[3:0] < threshold);

  always_comb begin
    threshold = 4'd15;
    case (density)
      2'd0:    threshold = 4'd4;
      2'd1:    threshold = 4'd8;
      2'd2:    threshold = 4'd12;
      default: threshold = 4'd15;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    gap_d   = gap_q;
    rn_d    = randomNumber;
    if (step_edge) begin
      case (state_q)
        FREE: begin
          rn_d = candidate;
          if (candidate) begin
            state_d = CAR;
            run_d   = 4'd1;
          end
        end
        CAR: begin
          if (candidate && (run_q < MAX_RUN_C)) begin
            rn_d  = 1'b1;
            run_d = run_q + 4'd1;
          end else begin
            rn_d    = 1'b0;
            gap_d   = 4'd1;
            state_d = (MIN_GAP_C == 4'd1) ? FREE : GAP;
          end
        end
        GAP: begin
          rn_d  = 1'b0;
          gap_d = gap_q + 4'd1;
          if ((gap_q + 4'd1) == MIN_GAP_C) state_d = FREE;
        end
        default: state_d = FREE;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= FREE;
      run_q        <= 4'd0;
      gap_q        <= 4'd0;
      randomNumber <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      gap_q        <= gap_d;
      randomNumber <= rn_d;
    end
  end

  // Divider and LFSR both hold while enable is low, so cadence resumes where it froze.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= 16'd0;
      lfsr    <= SEED_EFF;
      step    <= 1'b0;
    end else begin
      step <= step_edge;
      if (step_edge) begin
        div_cnt <= 16'd0;
        lfsr    <= {lfsr[14:0], feedback};
      end else if (enable) begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

`ifdef TRAFFIC_SPAWN_COUNT_EN
  logic run_start;
  assign run_start = step_edge && (state_q == FREE) && candidate;

  always_ff @(posedge clock) begin
    if (reset) begin
      carCount <= 8'd0;
    end else if (run_start && (carCount != 8'hFF)) begin
      carCount <= carCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_spawner.sv
// Directed bench for traffic_spawner: cadence, hand-computed step table, run/gap limits,
// freeze, reset mid-run, zero seed and (with TRAFFIC_SPAWN_COUNT_EN) carCount saturation.
module tb_traffic_spawner;

  localparam int DIV_A = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, enable, aux_reset;
  logic [1:0] density;
  logic       rn_a, step_a, rn_z, step_z, rn_s, step_s;
`ifdef TRAFFIC_SPAWN_COUNT_EN
  logic [7:0] cc_a, cc_z, cc_s;
`endif
  logic done_z, done_s;
  int total = 0;
  int bad   = 0;

  traffic_spawner #(.SEED(16'hACE1), .DIVIDE(DIV_A), .MAX_RUN(3), .MIN_GAP(2)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .density(density),
    .randomNumber(rn_a), .step(step_a)
`ifdef TRAFFIC_SPAWN_COUNT_EN
    , .carCount(cc_a)
`endif
  );

  traffic_spawner #(.SEED(16'h0000), .DIVIDE(2), .MAX_RUN(3), .MIN_GAP(2)) dut_z (
    .clock(clock), .reset(aux_reset), .enable(enable), .density(2'd1),
    .randomNumber(rn_z), .step(step_z)
`ifdef TRAFFIC_SPAWN_COUNT_EN
    , .carCount(cc_z)
`endif
  );

  traffic_spawner #(.SEED(16'hACE1), .DIVIDE(2), .MAX_RUN(1), .MIN_GAP(1)) dut_s (
    .clock(clock), .reset(aux_reset), .enable(enable), .density(2'd3),
    .randomNumber(rn_s), .step(step_s)
`ifdef TRAFFIC_SPAWN_COUNT_EN
    , .carCount(cc_s)
`endif
  );

  typedef struct {
    logic [15:0] lfsr;
    int          st;   // 0 FREE, 1 CAR, 2 GAP
    int          run;
    int          gap;
    logic        rn;
    int          cars;
  } model_t;

  typedef struct {
    logic [1:0]  density;
    logic        exp_rn;
    logic [15:0] exp_lfsr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout, want event", name);
  endtask

  function automatic model_t model_init(input logic [15:0] seed);
    model_t m;
    m.lfsr = (seed == 16'd0) ? 16'hACE1 : seed;
    m.st = 0; m.run = 0; m.gap = 0; m.rn = 1'b0; m.cars = 0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m_in, input logic [1:0] d,
                                        input int max_run, input int min_gap);
    model_t m;
    int     t;
    logic   cand, fb;
    m    = m_in;
    t    = (d == 2'd0) ? 4 : (d == 2'd1) ? 8 : (d == 2'd2) ? 12 : 15;
    cand = (int'(m.lfsr[3:0]) < t);
    fb   = m.lfsr[15] ^ m.lfsr[13] ^ m.lfsr[12] ^ m.lfsr[10];
    m.lfsr = {m.lfsr[14:0], fb};
    if (m.st == 0) begin
      m.rn = cand;
      if (cand) begin
        m.st = 1; m.run = 1;
        m.cars = (m.cars < 255) ? m.cars + 1 : 255;
      end
    end else if (m.st == 1) begin
      if (cand && m.run < max_run) begin
        m.rn = 1'b1; m.run++;
      end else begin
        m.rn = 1'b0; m.gap = 1;
        m.st = (min_gap == 1) ? 0 : 2;
      end
    end else begin
      m.rn = 1'b0; m.gap++;
      if (m.gap == min_gap) m.st = 0;
    end
    return m;
  endfunction

  task automatic wait_step(input int budget, output int edges, output logic ok);
    edges = 0;
    ok    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      edges++;
      if (step_a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("step_timeout");
  endtask

  task automatic step_main(input string name, input logic [1:0] d, inout model_t m);
    int   edges;
    logic ok;
    density = d;
    wait_step(2 * DIV_A, edges, ok);
    if (ok) begin
      m = model_step(m, d, 3, 2);
      check(name, rn_a, m.rn);
    end
  endtask

  // Zero-seed instance: LFSR must track the model and never read zero.
  initial begin : aux_z
    model_t mz;
    int     steps;
    steps  = 0;
    done_z = 1'b0;
    wait (aux_reset == 1'b0);
    mz = model_init(16'h0000);
    for (int c = 0; c < 30000 && steps < 10000; c++) begin
      @(posedge clock); #1;
      if (step_z) begin
        mz = model_step(mz, 2'd1, 3, 2);
        steps++;
        check("z_lfsr", dut_z.lfsr, mz.lfsr);
        check("z_nonzero", 32'(dut_z.lfsr != 16'd0), 1);
        check("z_rn", rn_z, mz.rn);
      end
    end
    if (steps < 10000) fail_now("z_budget");
    done_z = 1'b1;
  end

  // MAX_RUN=1 / MIN_GAP=1 instance at density 3: exercises the CAR->FREE path and carCount.
  initial begin : aux_s
    model_t ms;
    int     steps;
    steps  = 0;
    done_s = 1'b0;
    wait (aux_reset == 1'b0);
    ms = model_init(16'hACE1);
    for (int c = 0; c < 3000 && steps < 600; c++) begin
      @(posedge clock); #1;
      if (step_s) begin
        ms = model_step(ms, 2'd3, 1, 1);
        steps++;
        check("s_rn", rn_s, ms.rn);
`ifdef TRAFFIC_SPAWN_COUNT_EN
        check("s_carcount", cc_s, ms.cars);
`endif
      end
    end
    if (steps < 600) fail_now("s_budget");
    done_s = 1'b1;
  end

  initial begin : main
    vec_t   vecs[11];
    model_t m;
    int     edges, ones, zeros;
    logic   ok, seen_run, found;

    // Hand-derived from seed 16'hACE1 with MAX_RUN=3, MIN_GAP=2.
    vecs[0]  = '{2'd0, 1'b1, 16'h59C3};
    vecs[1]  = '{2'd0, 1'b1, 16'hB387};
    vecs[2]  = '{2'd1, 1'b1, 16'h670F};
    vecs[3]  = '{2'd3, 1'b0, 16'hCE1E};
    vecs[4]  = '{2'd3, 1'b0, 16'h9C3C};
    vecs[5]  = '{2'd2, 1'b0, 16'h3879};
    vecs[6]  = '{2'd3, 1'b1, 16'h70F2};
    vecs[7]  = '{2'd0, 1'b1, 16'hE1E4};
    vecs[8]  = '{2'd0, 1'b0, 16'hC3C8};
    vecs[9]  = '{2'd3, 1'b0, 16'h8791};
    vecs[10] = '{2'd0, 1'b1, 16'h0F22};

    reset = 1'b1; aux_reset = 1'b1; enable = 1'b1; density = 2'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_rn", rn_a, 0);
    check("rst_step", step_a, 0);
    check("rst_lfsr", dut_a.lfsr, 16'hACE1);
    check("rst_div", dut_a.div_cnt, 0);
    check("rst_lfsr_zero_seed", dut_z.lfsr, 16'hACE1);
`ifdef TRAFFIC_SPAWN_COUNT_EN
    check("rst_carcount", cc_a, 0);
`endif

    // Cadence: step high only after edges 4, 8, 12.
    reset = 1'b0; aux_reset = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clock); #1;
      check($sformatf("cadence_%0d", c), step_a, 32'((c % 4) == 0));
    end

    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m = model_init(16'hACE1);

    for (int i = 0; i < 11; i++) begin
      density = vecs[i].density;
      wait_step(2 * DIV_A, edges, ok);
      if (i == 0) check("first_step_latency", edges, DIV_A);
      check($sformatf("tbl_rn_%0d", i), rn_a, vecs[i].exp_rn);
      check($sformatf("tbl_lfsr_%0d", i), dut_a.lfsr, vecs[i].exp_lfsr);
      m = model_step(m, vecs[i].density, 3, 2);
    end

    // Density 3 soak: bit-exact with the model, runs <= 3, gaps >= 2.
    ones = 0; zeros = 0; seen_run = 1'b0;
    for (int s = 0; s < 500; s++) begin
      step_main("dens_rn", 2'd3, m);
      if (rn_a) begin
        if (ones == 0 && seen_run) check("dens_gap_ge2", 32'(zeros >= 2), 1);
        ones++;
        zeros = 0;
        check("dens_run_le3", 32'(ones <= 3), 1);
      end else begin
        if (ones > 0) seen_run = 1'b1;
        ones = 0;
        zeros++;
      end
    end

    // Freeze mid-run.
    found = 1'b0;
    for (int k = 0; k < 64; k++) begin
      step_main("find_car_a", 2'd3, m);
      if (rn_a) begin found = 1'b1; break; end
    end
    if (!found) fail_now("find_car_a");
    @(posedge clock); #1;
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      check("freeze_step", step_a, 0);
    end
    check("freeze_lfsr", dut_a.lfsr, m.lfsr);
    check("freeze_rn", rn_a, 1);
    check("freeze_div", dut_a.div_cnt, 1);
`ifdef TRAFFIC_SPAWN_COUNT_EN
    check("freeze_carcount", cc_a, m.cars);
`endif
    enable = 1'b1;
    wait_step(2 * DIV_A, edges, ok);
    check("resume_edges", edges, DIV_A - 1);
    m = model_step(m, 2'd3, 3, 2);
    check("resume_rn", rn_a, m.rn);

    // Reset on the same edge a step would have occurred, while in CAR.
    found = 1'b0;
    for (int k = 0; k < 64; k++) begin
      step_main("find_car_b", 2'd3, m);
      if (rn_a) begin found = 1'b1; break; end
    end
    if (!found) fail_now("find_car_b");
    repeat (DIV_A - 1) @(posedge clock);
    #1;
    check("pre_reset_rn", rn_a, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_reset_rn", rn_a, 0);
    check("mid_reset_step", step_a, 0);
    check("mid_reset_lfsr", dut_a.lfsr, 16'hACE1);
    density = 2'd0;
    wait_step(2 * DIV_A, edges, ok);
    check("post_reset_latency", edges, DIV_A);
    check("post_reset_rn", rn_a, 1);
    check("post_reset_lfsr", dut_a.lfsr, 16'h59C3);

    ok = 1'b0;
    for (int c = 0; c < 40000; c++) begin
      if (done_z && done_s) begin ok = 1'b1; break; end
      @(posedge clock);
    end
    if (!ok) fail_now("aux_done");
`ifdef TRAFFIC_SPAWN_COUNT_EN
    #1;
    check("carcount_saturated", cc_s, 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
